apu_output_pingpong_buf: RTL and testbench
==========================================

// Module: apu_output_pingpong_buf
// PURPOSE
//  Double-buffered result store for the APU output side. Sits directly downstream of
//  axi_apu_wrapper and consumes its wr_en_out/wr_addr_out/wr_data_out/wr_EvTID_done.
//  Event N fills one bank while readout drains event N-1 from the other.
//  evt_space_out is ANDed into the upstream rd_EvTID_ready so no event starts without a free bank.
// PARAMETERS
//  ADDR_WIDTH  10   word address width; each bank holds 2**ADDR_WIDTH words
//  DATA_WIDTH  128  word width; matches the APU write data
// PORTS
//  clk            in   1             system clock
//  reset          in   1             synchronous, active-high reset
//  wr_en_in       in   1             write strobe from wrapper
//  wr_addr_in     in   ADDR_WIDTH    write word address
//  wr_data_in     in   DATA_WIDTH    write data
//  wr_done_in     in   1             1-cycle pulse: event output complete (wr_EvTID_done)
//  evt_space_out  out  1             current write bank is free (gate for rd_EvTID_ready)
//  ro_valid_out   out  1             a completed event is available to read
//  ro_len_out     out  ADDR_WIDTH+1  accepted-word count of the readable event
//  ro_rd_en       in   1             readout read strobe
//  ro_rd_addr     in   ADDR_WIDTH    readout word address
//  ro_rd_data     out  DATA_WIDTH    read data, 1 cycle after ro_rd_en
//  ro_release     in   1             1-cycle pulse: readable bank consumed, free it
//  bank_full_out  out  2             per-bank full flags (status)
//  overflow_out   out  1             sticky: write or done seen while write bank was full
// BEHAVIOUR
//  - State: wr_bank, rd_bank (1b each), full[1:0], len0/len1 and wr_cnt (ADDR_WIDTH+1 each).
//    Memory: two 2**ADDR_WIDTH x DATA_WIDTH banks, not reset.
//  - Reset: wr_bank=rd_bank=0, full=00, wr_cnt=0, len0=len1=0, ro_rd_data=0, overflow_out=0.
//    Derived outputs after reset: evt_space_out=1, ro_valid_out=0, ro_len_out=0, bank_full_out=00.
//    A reset mid-event discards the partial event and both banks.
//  - All decisions in a cycle use the full[] values registered at the start of that cycle.
//  - Write, full[wr_bank]=0:
//    - wr_en_in writes bank[wr_bank][wr_addr_in].
//    - wr_cnt increments and saturates at 2**ADDR_WIDTH.
//    - Re-writing an address counts again. len counts writes, not the highest address.
//  - Write, full[wr_bank]=1: the write is dropped and overflow_out is set.
//  - wr_done_in, full[wr_bank]=0:
//    - len[wr_bank] <= wr_cnt, including a write accepted in the same cycle.
//    - full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
//    - An event with 0 writes is legal and gives len=0.
//  - wr_done_in, full[wr_bank]=1: ignored and overflow_out is set. overflow_out clears only on reset.
//  - evt_space_out = ~full[wr_bank], combinational from registers.
//  - ro_valid_out = full[rd_bank]; ro_len_out = len[rd_bank]; bank_full_out = full.
//  - Read:
//    - ro_rd_en registers bank[rd_bank][ro_rd_addr] into ro_rd_data on the next edge.
//    - ro_rd_data holds when ro_rd_en=0.
//    - Reads are allowed when ro_valid_out=0 (data is undefined but harmless).
//  - ro_release, ro_valid_out=1: full[rd_bank] <= 0 and rd_bank toggles.
//    ro_release with ro_valid_out=0 is ignored.
//  - Same-cycle release and done:
//    - On different banks, both take effect.
//    - When wr_bank==rd_bank and that bank is full, done is an overflow (pre-cycle flags)
//      while release frees the bank. evt_space_out rises the next cycle.
//  - Order: banks drain strictly in fill order. rd_bank always trails or equals wr_bank.
// TESTING
//  1. Reset, write addr 0..3 with data 0xA0..0xA3, pulse done
//     -> ro_valid_out=1, ro_len_out=4, bank_full_out=01; read addr 2 -> 0xA2 one cycle later.
//  2. Fill event A (2 words) and event B (3 words) with no release
//     -> evt_space_out=0, bank_full_out=11.
//     Release -> ro_len_out=3, evt_space_out=1 next cycle.
//  3. Both banks full, then assert wr_en_in plus done -> overflow_out=1, contents unchanged.
//     After 2 releases -> ro_valid_out=0, overflow_out stays 1.
//  4. Write on the same cycle as done -> that word is counted: 5 writes with done on the 5th -> len=5.
//     Done with no writes -> len=0, ro_valid_out=1.
//  5. Same-cycle release(bank0) and done(bank1) -> bank_full_out goes 01->10, rd_bank=1.
//  6. Reset asserted mid-fill after 3 writes -> all outputs at reset values;
//     next event of 2 writes reports len=2 from bank 0.

Source files
------------

// File: rtl/apu_output_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module   : apu_output_pingpong_buf
//  Purpose  : Two-bank result store for the APU output side. One bank is
//             filled with the current event while the other is drained by
//             readout. Banks are released strictly in fill order.
//  Revision : 1.0  initial release
// ============================================================================
module apu_output_pingpong_buf #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic                  wr_done_in,
    output logic                  evt_space_out,
    output logic                  ro_valid_out,
    output logic [ADDR_WIDTH:0]   ro_len_out,
    input  logic                  ro_rd_en,
    input  logic [ADDR_WIDTH-1:0] ro_rd_addr,
    output logic [DATA_WIDTH-1:0] ro_rd_data,
    input  logic                  ro_release,
    output logic [1:0]            bank_full_out,
    output logic                  overflow_out
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] r_mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem1 [DEPTH];

    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [1:0]          r_full;
    logic [ADDR_WIDTH:0] r_len0;
    logic [ADDR_WIDTH:0] r_len1;
    logic [ADDR_WIDTH:0] r_wr_cnt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                r_overflow;

    logic                w_wr_full;
    logic                w_wr_ok;
    logic                w_done_ok;
    logic                w_rel_ok;
    logic [ADDR_WIDTH:0] w_cnt_next;
    logic [1:0]          w_full_next;

    // All accept/ignore decisions use the flags registered at cycle start.
    always_comb begin
        w_wr_full  = r_full[r_wr_bank];
        w_wr_ok    = wr_en_in & ~w_wr_full;
        w_done_ok  = wr_done_in & ~w_wr_full;
        w_rel_ok   = ro_release & r_full[r_rd_bank];
        // A write landing in the same cycle as done belongs to the closing event.
        w_cnt_next = r_wr_cnt;
        if (w_wr_ok && (r_wr_cnt != C_CNT_MAX)) begin
            w_cnt_next = r_wr_cnt + 1'b1;
        end
        // done only sets a free bank and release only clears a full one,
        // so the two can never touch the same bit in one cycle.
        w_full_next = r_full;
        if (w_done_ok) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_rel_ok) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    // Bank 0 storage; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_ok && (r_wr_bank == 1'b0)) begin
            r_mem0[wr_addr_in] <= wr_data_in;
        end
    end

    // Bank 1 storage; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_ok && (r_wr_bank == 1'b1)) begin
            r_mem1[wr_addr_in] <= wr_data_in;
        end
    end

    // Registered readout port from the currently readable bank; holds when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (ro_rd_en) begin
            r_rd_data <= r_rd_bank ? r_mem1[ro_rd_addr] : r_mem0[ro_rd_addr];
        end
    end

    // Bank bookkeeping: fill count, event lengths, full flags, bank pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_full     <= 2'b00;
            r_len0     <= '0;
            r_len1     <= '0;
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_done_ok) begin
                if (r_wr_bank) begin
                    r_len1 <= w_cnt_next;
                end else begin
                    r_len0 <= w_cnt_next;
                end
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_cnt <= w_cnt_next;
            end
            if (w_rel_ok) begin
                r_rd_bank <= ~r_rd_bank;
            end
            // Sticky: any write or done aimed at a bank still awaiting readout.
            if ((wr_en_in | wr_done_in) & w_wr_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign evt_space_out = ~r_full[r_wr_bank];
    assign ro_valid_out  = r_full[r_rd_bank];
    assign ro_len_out    = r_rd_bank ? r_len1 : r_len0;
    assign bank_full_out = r_full;
    assign overflow_out  = r_overflow;
    assign ro_rd_data    = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_apu_output_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apu_output_pingpong_buf
//  Purpose  : Directed self-checking bench for apu_output_pingpong_buf with an
//             event-queue reference model and per-cycle output comparison.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apu_output_pingpong_buf;

    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en_in;
    logic [AW-1:0] wr_addr_in;
    logic [DW-1:0] wr_data_in;
    logic          wr_done_in;
    logic          evt_space_out;
    logic          ro_valid_out;
    logic [AW:0]   ro_len_out;
    logic          ro_rd_en;
    logic [AW-1:0] ro_rd_addr;
    logic [DW-1:0] ro_rd_data;
    logic          ro_release;
    logic [1:0]    bank_full_out;
    logic          overflow_out;

    apu_output_pingpong_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en_in      (wr_en_in),
        .wr_addr_in    (wr_addr_in),
        .wr_data_in    (wr_data_in),
        .wr_done_in    (wr_done_in),
        .evt_space_out (evt_space_out),
        .ro_valid_out  (ro_valid_out),
        .ro_len_out    (ro_len_out),
        .ro_rd_en      (ro_rd_en),
        .ro_rd_addr    (ro_rd_addr),
        .ro_rd_data    (ro_rd_data),
        .ro_release    (ro_release),
        .bank_full_out (bank_full_out),
        .overflow_out  (overflow_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: completed events form a FIFO of at most two lengths.
    // Bank of the k-th completed event is k mod 2; readable bank is the
    // bank of the oldest unreleased event.
    logic [DW-1:0] m_mem   [2][DEPTH];
    bit            m_known [2][DEPTH];
    int            q_len[$];
    int            n_done  = 0;
    int            n_rel   = 0;
    int            m_cnt   = 0;
    bit            m_ovf   = 0;
    logic [DW-1:0] m_rd    = '0;
    bit            m_rd_known = 0;

    always @(posedge clk) begin
        bit space;
        bit avail;
        int wb;
        int rb;
        if (reset) begin
            q_len.delete();
            n_done = 0; n_rel = 0; m_cnt = 0; m_ovf = 0;
            m_rd = '0; m_rd_known = 1;
        end else begin
            space = (q_len.size() < 2);
            avail = (q_len.size() > 0);
            wb = n_done % 2;
            rb = n_rel % 2;
            if (ro_rd_en) begin
                m_rd_known = m_known[rb][ro_rd_addr];
                m_rd       = m_mem[rb][ro_rd_addr];
            end
            if (wr_en_in) begin
                if (space) begin
                    m_mem[wb][wr_addr_in]   = wr_data_in;
                    m_known[wb][wr_addr_in] = 1;
                    if (m_cnt < DEPTH) m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (ro_release && avail) begin
                void'(q_len.pop_front());
                n_rel++;
            end
            if (wr_done_in) begin
                if (space) begin
                    q_len.push_back(m_cnt);
                    n_done++;
                    m_cnt = 0;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    // Compare every settled output against the model once per cycle.
    always @(negedge clk) begin
        logic [1:0] exp_full;
        exp_full = 2'b00;
        for (int i = 0; i < q_len.size(); i++) exp_full[(n_rel + i) % 2] = 1'b1;
        chk("mdl_evt_space", {31'd0, evt_space_out}, {31'd0, q_len.size() < 2});
        chk("mdl_ro_valid", {31'd0, ro_valid_out}, {31'd0, q_len.size() > 0});
        if (q_len.size() > 0) chk("mdl_ro_len", {28'd0, ro_len_out}, q_len[0]);
        chk("mdl_bank_full", {30'd0, bank_full_out}, {30'd0, exp_full});
        chk("mdl_overflow", {31'd0, overflow_out}, {31'd0, m_ovf});
        if (m_rd_known) chk("mdl_rd_data", {16'd0, ro_rd_data}, {16'd0, m_rd});
    end

    task automatic cyc();
        @(negedge clk);
        wr_en_in = 0; wr_done_in = 0; ro_rd_en = 0; ro_release = 0; reset = 0;
    endtask

    task automatic wr(input int a, input int d, input bit done = 0);
        logic [31:0] av, dv;
        av = a; dv = d;
        wr_en_in = 1; wr_addr_in = av[AW-1:0]; wr_data_in = dv[DW-1:0]; wr_done_in = done;
        cyc();
    endtask

    task automatic done_p();
        wr_done_in = 1;
        cyc();
    endtask

    task automatic rel_p();
        ro_release = 1;
        cyc();
    endtask

    task automatic rd(input int a);
        logic [31:0] av;
        av = a;
        ro_rd_en = 1; ro_rd_addr = av[AW-1:0];
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1; wr_en_in = 0; wr_addr_in = '0; wr_data_in = '0; wr_done_in = 0;
        ro_rd_en = 0; ro_rd_addr = '0; ro_release = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_evt_space", {31'd0, evt_space_out}, 1);
        chk("rst_ro_valid", {31'd0, ro_valid_out}, 0);
        chk("rst_ro_len", {28'd0, ro_len_out}, 0);
        chk("rst_bank_full", {30'd0, bank_full_out}, 0);
        chk("rst_overflow", {31'd0, overflow_out}, 0);
        chk("rst_rd_data", {16'd0, ro_rd_data}, 0);
        reset = 0;

        // 1: single event, readback
        for (int i = 0; i < 4; i++) wr(i, 'hA0 + i);
        done_p();
        chk("t1_valid", {31'd0, ro_valid_out}, 1);
        chk("t1_len", {28'd0, ro_len_out}, 4);
        chk("t1_full", {30'd0, bank_full_out}, 2'b01);
        rd(2);
        chk("t1_rd_data", {16'd0, ro_rd_data}, 'hA2);
        cyc();
        chk("t1_rd_hold", {16'd0, ro_rd_data}, 'hA2);
        rel_p();

        // 2: two events queued, drain in order
        wr(0, 'hA0); wr(1, 'hA1); done_p();
        wr(0, 'hB0); wr(1, 'hB1); wr(2, 'hB2); done_p();
        chk("t2_space", {31'd0, evt_space_out}, 0);
        chk("t2_full", {30'd0, bank_full_out}, 2'b11);
        chk("t2_lenA", {28'd0, ro_len_out}, 2);
        rel_p();
        chk("t2_lenB", {28'd0, ro_len_out}, 3);
        chk("t2_space_after", {31'd0, evt_space_out}, 1);

        // 3: overflow while both banks full; B must stay intact
        wr(0, 'hC0); done_p();
        wr(0, 'hFFFF, 1);
        chk("t3_overflow", {31'd0, overflow_out}, 1);
        chk("t3_len_kept", {28'd0, ro_len_out}, 3);
        rd(0);
        chk("t3_contents", {16'd0, ro_rd_data}, 'hB0);
        rel_p(); rel_p();
        chk("t3_valid", {31'd0, ro_valid_out}, 0);
        chk("t3_ovf_sticky", {31'd0, overflow_out}, 1);

        // 4: write with done counted; empty event; saturation; rewrites
        for (int i = 0; i < 4; i++) wr(i, 'h40 + i);
        wr(4, 'h44, 1);
        chk("t4_len5", {28'd0, ro_len_out}, 5);
        rel_p();
        done_p();
        chk("t4_len0", {28'd0, ro_len_out}, 0);
        chk("t4_valid0", {31'd0, ro_valid_out}, 1);
        rel_p();
        for (int i = 0; i < 9; i++) wr(i % DEPTH, 'h90 + i);
        done_p();
        chk("t4_sat", {28'd0, ro_len_out}, DEPTH);
        rd(0);
        chk("t4_rewrite_data", {16'd0, ro_rd_data}, 'h98);
        rel_p();
        wr(5, 'h51); wr(5, 'h52); wr(5, 'h53); done_p();
        chk("t4_rewrites", {28'd0, ro_len_out}, 3);
        rel_p();

        // 5: release bank0 and done bank1 in the same cycle
        wr(0, 'h70); done_p();
        chk("t5_full_before", {30'd0, bank_full_out}, 2'b01);
        wr(0, 'h80); wr(1, 'h81);
        ro_release = 1; done_p();
        chk("t5_full_after", {30'd0, bank_full_out}, 2'b10);
        chk("t5_len_bank1", {28'd0, ro_len_out}, 2);
        rd(1);
        chk("t5_rd_bank1", {16'd0, ro_rd_data}, 'h81);
        rel_p();

        // 6: reset mid-fill
        wr(0, 'h11); wr(1, 'h12); wr(2, 'h13);
        reset = 1; cyc();
        chk("t6_space", {31'd0, evt_space_out}, 1);
        chk("t6_valid", {31'd0, ro_valid_out}, 0);
        chk("t6_len", {28'd0, ro_len_out}, 0);
        chk("t6_full", {30'd0, bank_full_out}, 0);
        chk("t6_overflow", {31'd0, overflow_out}, 0);
        chk("t6_rd_data", {16'd0, ro_rd_data}, 0);
        wr(0, 'h21); wr(1, 'h22); done_p();
        chk("t6_len2", {28'd0, ro_len_out}, 2);
        chk("t6_bank0", {30'd0, bank_full_out}, 2'b01);

        // 7: same bank full, done and release together
        wr(0, 'h31); done_p();
        chk("t7_full", {30'd0, bank_full_out}, 2'b11);
        ro_release = 1; done_p();
        chk("t7_overflow", {31'd0, overflow_out}, 1);
        chk("t7_full_after", {30'd0, bank_full_out}, 2'b10);
        chk("t7_space", {31'd0, evt_space_out}, 1);
        chk("t7_len", {28'd0, ro_len_out}, 1);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
